// File: rtl/vjtag_readback_if.sv
// Fabric-side valid/ready handshake carrying one readback word into vjtag_readback.
// master = fabric producer, slave = vjtag_readback.
interface vjtag_readback_if #(
  parameter int DW = 32
);
  logic [DW-1:0] fab_data;
  logic          fab_valid;
  logic          fab_ready;

  modport master (output fab_data, output fab_valid, input fab_ready);
  modport slave  (input fab_data, input fab_valid, output fab_ready);
endinterface

// File: rtl/vjtag_readback.sv
// vjtag_readback: read direction of the vJTAG link.
// A fabric word is held in a snapshot register (clk domain) and captured into a
// DW+8 bit DR (tck domain) as {data, hdr}. hdr[0] = valid, hdr[7:1] = sequence number.
// The DR is shifted out LSB-first on tdo. Update-DR hands the snapshot back to
// the fabric through a toggle handshake.
// Optional feature: define VJTAG_RB_SEQ_EN to build the 7-bit sequence counter.
// When it is undefined, hdr[7:1] reads as zero and the DR length is unchanged.
module vjtag_readback #(
  parameter int         DW          = 32,
  parameter logic [2:0] IR_READ     = 3'b010,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   aclr,
  vjtag_readback_if.slave        fab,
  input  logic                   tck_i,
  input  logic                   tdi_i,
  input  logic [2:0]             ir_in_i,
  input  logic                   v_cdr_i,
  input  logic                   v_sdr_i,
  input  logic                   v_udr_i,
  output logic                   tdo_o
);

  localparam int DRW = DW + 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // ---------------- clk domain ----------------
  state_t                 state_q, state_d;
  logic [DW-1:0]          snap_q, snap_d;
  logic [6:0]             seq_w;
  logic                   fab_ready_w;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_prev_q;
  logic                   ack_edge;

  // ---------------- tck domain ----------------
  logic [SYNC_STAGES-1:0] full_sync_q;
  logic                   full_t;
  logic [DRW-1:0]         shreg_q;
  logic                   bypass_q;
  logic                   cap_valid_q;
  logic                   pending_q;
  logic                   ack_tgl_q;
  logic                   sel;
  logic                   avail;
  logic [DRW-1:0]         cap_frame;

`ifdef VJTAG_RB_SEQ_EN
  logic [6:0]             seq_q, seq_d;

  // Sequence counter register; increments on every accepted word, wraps 127->0.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) seq_q <= 7'd0;
    else      seq_q <= seq_d;
  end

  assign seq_w = seq_q;
`else
  assign seq_w = 7'd0;
`endif

  // A toggle edge coming back from tck means the host has consumed the snapshot.
  assign ack_edge = ack_sync_q[SYNC_STAGES-1] ^ ack_prev_q;

  // Snapshot FSM state and data registers.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q <= EMPTY;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
    end
  end

  // Next state: load the word when empty, hold it stable until acknowledged.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    fab_ready_w = 1'b0;
`ifdef VJTAG_RB_SEQ_EN
    seq_d       = seq_q;
`endif
    case (state_q)
      EMPTY: begin
        fab_ready_w = 1'b1;
        if (fab.fab_valid) begin
          state_d = FULL;
          snap_d  = fab.fab_data;
`ifdef VJTAG_RB_SEQ_EN
          seq_d   = seq_q + 7'd1;
`endif
        end
      end
      FULL: begin
        // fab_valid is ignored here; the producer stalls on fab_ready=0.
        if (ack_edge) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  assign fab.fab_ready = fab_ready_w;

  // Bring the tck-side ack toggle into clk and remember its last value for edge detection.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      ack_sync_q <= '0;
      ack_prev_q <= 1'b0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_tgl_q};
      ack_prev_q <= ack_sync_q[SYNC_STAGES-1];
    end
  end

  // Bring the snapshot-full level into tck.
  always_ff @(posedge tck_i or posedge aclr) begin
    if (aclr) full_sync_q <= '0;
    else      full_sync_q <= {full_sync_q[SYNC_STAGES-2:0], state_q == FULL};
  end

  assign full_t = full_sync_q[SYNC_STAGES-1];

  // snap_q/seq_w are only sampled while full_t is high, when they are quasi-static.
  assign sel       = (ir_in_i == IR_READ);
  assign avail     = full_t & ~pending_q;
  assign cap_frame = avail ? {snap_q, seq_w, 1'b1} : '0;

  // JTAG-side DR, bypass and ack handshake. pending blocks a second read of a
  // word already acknowledged until the fabric side has actually emptied.
  always_ff @(posedge tck_i or posedge aclr) begin
    if (aclr) begin
      shreg_q     <= '0;
      bypass_q    <= 1'b0;
      cap_valid_q <= 1'b0;
      pending_q   <= 1'b0;
      ack_tgl_q   <= 1'b0;
    end else begin
      bypass_q <= tdi_i;
      if (sel && v_cdr_i) begin
        shreg_q     <= cap_frame;
        cap_valid_q <= avail;
      end else if (sel && v_sdr_i) begin
        shreg_q <= {tdi_i, shreg_q[DRW-1:1]};
      end
      if (sel && v_udr_i && cap_valid_q) begin
        ack_tgl_q   <= ~ack_tgl_q;
        pending_q   <= 1'b1;
        cap_valid_q <= 1'b0;
      end else if (!full_t) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign tdo_o = sel ? shreg_q[0] : bypass_q;

endmodule

// File: tb/tb_vjtag_readback.sv
// Scoreboard bench for vjtag_readback: random fabric words, JTAG capture/shift
// frames compared against frames built from the word/sequence model.
module tb_vjtag_readback;
  localparam int         DW      = 32;
  localparam logic [2:0] IR_READ = 3'b010;
  localparam int         SS      = 2;

  logic       clk = 1'b0;
  logic       tck = 1'b0;
  logic       aclr = 1'b1;
  logic       tdi = 1'b0;
  logic       v_cdr = 1'b0;
  logic       v_sdr = 1'b0;
  logic       v_udr = 1'b0;
  logic [2:0] ir = 3'b000;
  logic       tdo;

  vjtag_readback_if #(.DW(DW)) fab_if ();

  vjtag_readback #(.DW(DW), .IR_READ(IR_READ), .SYNC_STAGES(SS)) dut (
    .clk     (clk),
    .aclr    (aclr),
    .fab     (fab_if.slave),
    .tck_i   (tck),
    .tdi_i   (tdi),
    .ir_in_i (ir),
    .v_cdr_i (v_cdr),
    .v_sdr_i (v_sdr),
    .v_udr_i (v_udr),
    .tdo_o   (tdo)
  );

  always #5 clk = ~clk;
  always #3 tck = ~tck;

  int errors = 0;
  int checks = 0;
  int frames = 0;
  int mdl_seq = 0;
  logic [39:0] exp_q[$];
  logic [39:0] act_q[$];

  // Expected DR contents for a word: {data, seq, valid}; seq bits are zero without the counter.
  function automatic logic [39:0] frame_of(input logic [31:0] d, input int s);
    logic [6:0] sq;
    sq = s[6:0];
`ifndef VJTAG_RB_SEQ_EN
    sq = 7'd0;
`endif
    return {d, sq, 1'b1};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Monitor: compare every shifted-out frame against the oldest expected frame.
  initial begin
    logic [39:0] a, e;
    forever begin
      @(posedge tck);
      while (act_q.size() > 0) begin
        a = act_q.pop_front();
        checks++;
        frames++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_%0d: got=%010h expected=<none>", frames, a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL frame_%0d: got=%010h expected=%010h", frames, a, e);
          end else begin
            $display("frame %0d ok: data=%08h hdr=%02h", frames, a[39:8], a[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge tck);
  endtask

  // Offer one word to the fabric port and wait for acceptance.
  task automatic post_word(input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    fab_if.fab_data  = d;
    fab_if.fab_valid = 1'b1;
    while (!fab_if.fab_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("post_accept", fab_if.fab_ready, 1);
    if (fab_if.fab_ready) begin
      @(posedge clk);
      #1;
      mdl_seq = (mdl_seq + 1) % 128;
    end
    fab_if.fab_valid = 1'b0;
  endtask

  // Capture-DR then 40 Shift-DR cycles; tdo is sampled before each shift edge.
  task automatic read_frame(input logic [39:0] exp);
    logic [39:0] f;
    exp_q.push_back(exp);
    @(negedge tck);
    ir    = IR_READ;
    v_cdr = 1'b1;
    @(negedge tck);
    v_cdr = 1'b0;
    v_sdr = 1'b1;
    for (int i = 0; i < 40; i++) begin
      f[i] = tdo;
      tdi  = 1'($urandom);
      @(negedge tck);
    end
    v_sdr = 1'b0;
    act_q.push_back(f);
  endtask

  task automatic update();
    @(negedge tck);
    ir    = IR_READ;
    v_udr = 1'b1;
    @(posedge tck);
    #1;
    v_udr = 1'b0;
  endtask

  // After Update-DR the fabric must see fab_ready within SS+2 clk edges.
  task automatic wait_ready();
    int n = 0;
    while (!fab_if.fab_ready && n < SS + 2) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("udr_ready", fab_if.fab_ready, 1);
  endtask

  initial begin
    logic [31:0] d, a_w, b_w;
    logic [39:0] e, exp_a;
    logic [3:0]  pat;

    fab_if.fab_data  = '0;
    fab_if.fab_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tdo", tdo, 0);
    chk("rst_ready", fab_if.fab_ready, 1);
    aclr = 1'b0;
    tick(4);

    // Empty snapshot reads as an all-zero frame.
    read_frame(40'd0);
    chk("empty_ready", fab_if.fab_ready, 1);

    // Known word, read twice without Update, then Update and immediate recapture.
    post_word(32'hDEADBEEF);
    chk("full_ready", fab_if.fab_ready, 0);
    tick(4);
    e = frame_of(32'hDEADBEEF, mdl_seq);
    read_frame(e);
    read_frame(e);
    update();
    fork
      wait_ready();
    join_none
    read_frame(40'd0);
    wait fork;
    tick(8);

    // Bypass path with a non-readback IR leaves the snapshot alone.
    d = $urandom;
    post_word(d);
    tick(4);
    pat = 4'b1011;
    @(negedge tck);
    ir    = 3'b001;
    v_sdr = 1'b1;
    tdi   = pat[0];
    for (int i = 1; i <= 4; i++) begin
      @(negedge tck);
      chk($sformatf("bypass_bit%0d", i - 1), tdo, pat[i-1]);
      if (i < 4) tdi = pat[i];
    end
    v_sdr = 1'b0;
    read_frame(frame_of(d, mdl_seq));
    update();
    wait_ready();
    tick(8);

    // Second word held off while the first is unread.
    a_w = $urandom;
    b_w = $urandom;
    post_word(a_w);
    exp_a = frame_of(a_w, mdl_seq);
    fork
      post_word(b_w);
    join_none
    repeat (6) @(negedge clk);
    chk("hold_off", fab_if.fab_ready, 0);
    tick(4);
    read_frame(exp_a);
    update();
    wait_ready();
    wait fork;
    tick(6);
    read_frame(frame_of(b_w, mdl_seq));
    update();
    wait_ready();
    tick(8);

    // Random words; enough of them for the sequence number to wrap.
    for (int it = 0; it < 130; it++) begin
      d = $urandom;
      post_word(d);
      tick(4);
      e = frame_of(d, mdl_seq);
      read_frame(e);
      if ($urandom_range(0, 3) == 0) read_frame(e);
      update();
      if ($urandom_range(0, 3) == 0) begin
        fork
          wait_ready();
        join_none
        read_frame(40'd0);
        wait fork;
      end else begin
        wait_ready();
      end
      tick(8);
    end

    // Reset in the middle of a shift.
    post_word($urandom);
    tick(4);
    @(negedge tck);
    ir    = IR_READ;
    v_cdr = 1'b1;
    @(negedge tck);
    v_cdr = 1'b0;
    v_sdr = 1'b1;
    tick(10);
    #1;
    aclr = 1'b1;
    #2;
    chk("aclr_tdo", tdo, 0);
    chk("aclr_ready", fab_if.fab_ready, 1);
    v_sdr = 1'b0;
    @(negedge clk);
    aclr    = 1'b0;
    mdl_seq = 0;
    tick(6);
    read_frame(40'd0);

    // Known word again from a fresh reset.
    post_word(32'hDEADBEEF);
    tick(4);
    read_frame(frame_of(32'hDEADBEEF, mdl_seq));
    update();
    wait_ready();

    for (int i = 0; i < 200 && act_q.size() != 0; i++) #5;
    #10;
    chk("scoreboard_drain", 64'(exp_q.size() + act_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
